// File: rtl/iot_pkg.sv
// Shared constants and types for the IoT event transmitter.
package iot_pkg;

    localparam int N_DEV_DEFAULT = 8;
    localparam int CW_DEFAULT    = 8;
    localparam int IDX_W_DEFAULT = $clog2(N_DEV_DEFAULT);

    typedef logic [IDX_W_DEFAULT-1:0] dev_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] k;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        k         = ptr;
        for (int i = 0; i < N; i++) begin
            if (en && !gnt_valid && req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = k;
            end
            k = (k == IW'(N - 1)) ? '0 : k + 1'b1;
        end
    end

endmodule

// File: rtl/iot_event_tx.sv
// Detects per-device on/off transitions and serialises them as
// one change/on_off event per cycle with round-robin fairness.
module iot_event_tx
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DEV-1:0]         dev_status,
    input  logic                     hold,
    output logic                     change,
    output logic                     on_off,
    output logic [$clog2(N_DEV)-1:0] dev_idx,
    output logic [N_DEV-1:0]         pending,
    output logic [CW-1:0]            active_cnt
);

    localparam int IW = $clog2(N_DEV);

    logic [N_DEV-1:0] status_q;
    logic [N_DEV-1:0] reported_q, reported_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_DEV-1:0] pend_q, pend_d;

    logic [N_DEV-1:0] diff;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_idx;

    assign diff = status_q ^ reported_q;

    rr_arbiter #(.N(N_DEV)) u_arb (
        .req       (diff),
        .ptr       (ptr_q),
        .en        (!hold),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        reported_d = reported_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        change_d   = 1'b0;
        on_off_d   = 1'b0;
        idx_d      = '0;
        if (gnt_valid) begin
            reported_d[gnt_idx] = status_q[gnt_idx];
            change_d            = 1'b1;
            on_off_d            = status_q[gnt_idx];
            idx_d               = gnt_idx;
            cnt_d = status_q[gnt_idx] ? cnt_q + CW'(1) : cnt_q - CW'(1);
            ptr_d = (gnt_idx == IW'(N_DEV - 1)) ? '0 : gnt_idx + 1'b1;
        end
        // A granted device drops out of the mask in the cycle its event shows.
        pend_d = status_q ^ reported_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= '0;
            reported_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            change_q   <= 1'b0;
            on_off_q   <= 1'b0;
            idx_q      <= '0;
            pend_q     <= '0;
        end else begin
            status_q   <= dev_status;
            reported_q <= reported_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            change_q   <= change_d;
            on_off_q   <= on_off_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
        end
    end

    assign change     = change_q;
    assign on_off     = on_off_q;
    assign dev_idx    = idx_q;
    assign pending    = pend_q;
    assign active_cnt = cnt_q;

endmodule

// File: tb/tb_iot_event_tx.sv
// Self-checking bench for iot_event_tx against a behavioural model.
module tb_iot_event_tx;
    import iot_pkg::*;

    localparam int N = N_DEV_DEFAULT;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   dev_status;
    logic           hold;
    logic           change;
    logic           on_off;
    dev_idx_t       dev_idx;
    logic [N-1:0]   pending;
    logic [7:0]     active_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] m_st, m_rep;
    int           m_ptr;
    logic         e_change, e_on;
    int           e_idx;
    logic [N-1:0] e_pend;
    int           e_cnt;
    int           mon;

    always #5 clk = ~clk;

    iot_event_tx dut (
        .clk        (clk),
        .rst        (rst),
        .dev_status (dev_status),
        .hold       (hold),
        .change     (change),
        .on_off     (on_off),
        .dev_idx    (dev_idx),
        .pending    (pending),
        .active_cnt (active_cnt)
    );

    // Advance model by one clock using current inputs, then step the DUT.
    task automatic tick();
        int g;
        g = -1;
        e_change = 1'b0;
        e_on     = 1'b0;
        e_idx    = 0;
        if (rst) begin
            m_st   = '0;
            m_rep  = '0;
            m_ptr  = 0;
            e_pend = '0;
        end else begin
            if (!hold)
                for (int k = 0; k < N; k++) begin
                    int d;
                    d = (m_ptr + k) % N;
                    if (g < 0 && m_st[d] != m_rep[d]) g = d;
                end
            if (g >= 0) begin
                e_change = 1'b1;
                e_on     = m_st[g];
                e_idx    = g;
                m_rep[g] = m_st[g];
                m_ptr    = (g + 1) % N;
            end
            e_pend = m_st ^ m_rep;
            m_st   = dev_status;
        end
        e_cnt = $countones(m_rep);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; dev_status = 8'hFF;
        tick(); tick();
        n_tests++;
        if (change !== 1'b0 || active_cnt !== 8'd0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: change=%0b cnt=%0d pend=%h, want 0/0/00", change, active_cnt, pending);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (change !== 1'b0 || active_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_release: change=%0b cnt=%0d, want 0/0", change, active_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (change !== 1'b1 || on_off !== 1'b1 || int'(dev_idx) !== i) begin
                n_fail++;
                $display("FAIL reset_burst[%0d]: change=%0b on=%0b idx=%0d, want 1/1/%0d",
                         i, change, on_off, dev_idx, i);
            end
        end
        n_tests++;
        if (active_cnt !== 8'd8) begin
            n_fail++;
            $display("FAIL reset_cnt: cnt=%0d, want 8", active_cnt);
        end
        tick();
    endtask

    task automatic test_single();
        dev_status = 8'hF7;
        tick();
        n_tests++;
        if (change !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: change=%0b, want 0", change);
        end
        tick();
        n_tests++;
        if (change !== 1'b1 || dev_idx !== 3'd3 || on_off !== 1'b0 ||
            active_cnt !== 8'd7 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_event: change=%0b idx=%0d on=%0b cnt=%0d pend=%h, want 1/3/0/7/00",
                     change, dev_idx, on_off, active_cnt, pending);
        end
        tick();
        n_tests++;
        if (change !== 1'b0) begin
            n_fail++;
            $display("FAIL single_once: change=%0b, want 0", change);
        end
    endtask

    task automatic test_round_robin();
        dev_status = 8'hE7;
        tick(); tick();
        n_tests++;
        if (change !== 1'b1 || dev_idx !== 3'd4) begin
            n_fail++;
            $display("FAIL rr_setup: change=%0b idx=%0d, want 1/4", change, dev_idx);
        end
        dev_status = 8'hA3;
        tick(); tick();
        n_tests++;
        if (change !== 1'b1 || dev_idx !== 3'd6 || on_off !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_first: change=%0b idx=%0d on=%0b, want 1/6/0", change, dev_idx, on_off);
        end
        tick();
        n_tests++;
        if (change !== 1'b1 || dev_idx !== 3'd2 || active_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL rr_second: change=%0b idx=%0d cnt=%0d, want 1/2/4", change, dev_idx, active_cnt);
        end
        tick();
    endtask

    task automatic test_glitch();
        logic [7:0] c0;
        dev_status = 8'hA1;
        tick(); tick(); tick();
        c0 = active_cnt;
        hold = 1'b1;
        dev_status = 8'hA3;
        tick();
        dev_status = 8'hA1;
        tick(); tick();
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (change !== 1'b0 || active_cnt !== c0) begin
                n_fail++;
                $display("FAIL glitch[%0d]: change=%0b cnt=%0d, want 0/%0d", i, change, active_cnt, c0);
            end
        end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        dev_status = dev_status ^ 8'h19;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (change !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_quiet[%0d]: change=%0b, want 0", i, change);
            end
        end
        n_tests++;
        if (pending !== 8'h19) begin
            n_fail++;
            $display("FAIL hold_pending: pend=%h, want 19", pending);
        end
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (change !== 1'b1 || int'(dev_idx) !== e_idx || on_off !== e_on) begin
                n_fail++;
                $display("FAIL hold_release[%0d]: change=%0b idx=%0d on=%0b, want 1/%0d/%0b",
                         i, change, dev_idx, on_off, e_idx, e_on);
            end
        end
        tick();
        n_tests++;
        if (change !== 1'b0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL hold_drain: change=%0b pend=%h, want 0/00", change, pending);
        end
    endtask

    task automatic test_random();
        logic was_rst;
        mon = int'(active_cnt);
        for (int c = 0; c < 500; c++) begin
            rst  = (c == 250 || c == 251);
            hold = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0)
                dev_status = dev_status ^ 8'($urandom & $urandom);
            was_rst = rst;
            tick();
            if (was_rst) mon = 0;
            else if (change) mon = on_off ? mon + 1 : mon - 1;
            n_tests++;
            if (change !== e_change || on_off !== e_on || int'(dev_idx) !== e_idx ||
                pending !== e_pend || int'(active_cnt) !== e_cnt) begin
                n_fail++;
                $display("FAIL rand[%0d]: chg=%0b on=%0b idx=%0d pend=%h cnt=%0d, want %0b/%0b/%0d/%h/%0d",
                         c, change, on_off, dev_idx, pending, active_cnt,
                         e_change, e_on, e_idx, e_pend, e_cnt);
            end
            n_tests++;
            if (int'(active_cnt) !== mon) begin
                n_fail++;
                $display("FAIL rand_monitor[%0d]: cnt=%0d, monitor=%0d", c, active_cnt, mon);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; dev_status = '0;
        m_st = '0; m_rep = '0; m_ptr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_glitch();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iot_event_tx.md
# iot_event_tx

Event transmitter for the Active IoT Devices Monitor. Tracks a vector of per-device on/off status lines, detects state transitions, and serialises them into the single-event change/on_off protocol consumed by `monitor`: at most one event per cycle, selected by a round-robin arbiter. The block sits directly upstream of `monitor`. Its `active_cnt` output is the reference value that `monitor.counter_out` must track.

## Interface

- `N_DEV`, 8, number of monitored devices (2..64)
- `CW`, 8, width of `active_cnt`; must satisfy 2^CW > N_DEV

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `dev_status`  in  N_DEV  current on(1)/off(0) state per device; synchronous to `clk`
- `hold`  in  1  1 = suppress event emission this cycle; pending events are retained
- `change`  out  1  registered; 1 = an event is presented this cycle
- `on_off`  out  1  registered; direction of the event (1 = device turned on, count up; 0 = turned off, count down); 0 when `change`=0
- `dev_idx`  out  $clog2(N_DEV)  registered; index of the device reported; 0 when `change`=0
- `pending`  out  N_DEV  registered mask of devices whose status differs from the last reported state
- `active_cnt`  out  CW  registered popcount of the reported state

## Operation

- State:
  - `status_q[N_DEV]`: input sample register.
  - `reported[N_DEV]`: last state sent downstream.
  - `ptr`: round-robin start index.
- Pending condition: `status_q ^ reported`, evaluated combinationally. `pending` registers this value.
- Each cycle with `hold`=0 and a non-zero pending set:
  - grant the lowest index ≥ `ptr` with a pending bit, wrapping modulo N_DEV;
  - next cycle: `change`=1, `on_off`=`status_q[idx]`, `dev_idx`=idx;
  - `reported[idx]` ← `status_q[idx]`;
  - `active_cnt` ±1;
  - `ptr` ← (idx+1) mod N_DEV.
- No pending bits, or `hold`=1: `change`=0, `on_off`=0, `dev_idx`=0. `reported`, `ptr` and `active_cnt` are unchanged.
- Glitch cancellation: if a device toggles and returns to its reported value before it is granted, its pending bit clears and no event is emitted. This is the intended net-zero behaviour.
- Invariant, every cycle: `active_cnt` == popcount(`reported`) ≤ N_DEV. The counter therefore never wraps.
- Fairness: a pending device is granted within N_DEV non-held cycles.
- Simultaneous toggles on multiple devices in one cycle are emitted as consecutive events, one per cycle, in round-robin order.
- Reset (any cycle, including mid-burst):
  - `status_q`, `reported` ← 0; `ptr` ← 0; `active_cnt` ← 0;
  - `change`, `on_off`, `dev_idx`, `pending` ← 0;
  - in-flight events are discarded.
  - Downstream `monitor` is reset by the same `rst`.

## Timing

- `dev_status` edge sampled at clock edge E; the earliest `change`=1 appears after edge E+1 (2-cycle latency).
- `pending` reflects a toggle after edge E+1, and clears in the same cycle that `change`=1 for that device is asserted.
- Throughput: 1 event/cycle sustained. A burst of k simultaneous toggles completes in k cycles.
- `hold` is sampled combinationally into the grant decision: `hold` high during cycle C forces `change`=0 after edge C+1.
- First cycle after `rst` deasserts: outputs are at reset values. `status_q` loads `dev_status` at that edge.

## Structure

- Package `iot_pkg`:
  - `N_DEV_DEFAULT`, `CW_DEFAULT` constants;
  - `dev_idx_t` typedef.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs: `req[N]`, `ptr`, `en`;
  - outputs: `gnt_valid`, `gnt_idx`;
  - purely combinational.
- Top level holds the sample, reported, ptr and output registers.

## Test plan

1. Reset: `rst`=1 for 2 cycles with `dev_status`=8'hFF → `change`=0, `active_cnt`=0, `pending`=0. After release: 8 events, `dev_idx` 0..7 in order, all `on_off`=1; `active_cnt` ends at 8.
2. Single toggle: device 3 goes 1→0 with `active_cnt`=8 → exactly one event, `dev_idx`=3, `on_off`=0, 2 cycles after the input edge; `active_cnt`=7.
3. Round-robin: `ptr`=5, devices 2 and 6 toggle together → events at `dev_idx`=6 then `dev_idx`=2 on consecutive cycles.
4. Glitch: device 1 toggles 0→1→0 within 1 cycle while `hold`=1 → no event for device 1 after `hold` drops; `active_cnt` unchanged.
5. Hold: 3 toggles pending, `hold`=1 for 10 cycles → `change`=0 throughout and `pending` has 3 bits set. After release: 3 events on consecutive cycles.
6. Integration with `monitor`: random `dev_status` for 500 cycles, with `rst` pulsed mid-burst → `monitor.counter_out` == `active_cnt` every cycle, and == popcount(`reported`).
